systolic_output_writer: RTL and testbench
=========================================

SYSTOLIC_OUTPUT_WRITER -- requirements
Module: systolic_output_writer

Interface
REQ-001 Parameter ROWS, default 4, systolic rows (= result rows), power of 2, >=2.
REQ-002 Parameter COLS, default 4, systolic columns, power of 2, >=2.
REQ-003 Parameter WORD_SIZE, default 16, bits per result word.
REQ-004 Parameter MEM_ACCESS_LATENCY, default 2, RAM write recovery cycles, >=1.
REQ-005 Parameter OUT_BASE_ADDR, default 32'h0000_0200, address of result row 0.
REQ-006 Parameter ADDR_INCR, default 4, address step per row.
REQ-007 clk  in  1  clock; all logic on posedge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 matmul_output  in  COLS*WORD_SIZE  systolic bottom_out bus; word c at [c*WORD_SIZE +: WORD_SIZE].
REQ-010 output_col_valid  in  COLS  bit c high = word c valid this cycle.
REQ-011 stall  in  1  matmul FSM memory stall; captures are suppressed while high.
REQ-012 fsm_done  in  1  matmul FSM finished; level, held until wr_output_done is seen.
REQ-013 wr_output_rdy  out  1  writer idle, buffer empty, new matmul may start.
REQ-014 wr_output_done  out  1  all result rows written to RAM.
REQ-015 wr_mem_addr  out  32  RAM write address.
REQ-016 wr_mem_en  out  1  RAM write strobe, one cycle per row.
REQ-017 wr_mem_data  out  COLS*WORD_SIZE  RAM write data, one full result row.
REQ-018 err_overflow  out  1  sticky: valid word arrived for a column already holding ROWS words.
REQ-019 err_short  out  1  sticky: fsm_done arrived before buffer full.

Function
REQ-020 States IDLE, CAPTURE, WRITE, WAIT_MEM, DONE; wr_output_rdy=1 only in IDLE.
REQ-021 Buffer ROWS x COLS words; per-column counter row_cnt[c] (0..ROWS).
REQ-022 In IDLE and CAPTURE, for each c with output_col_valid[c]=1 and stall=0 at posedge: if row_cnt[c]<ROWS store matmul_output word c at buf[row_cnt[c]][c], row_cnt[c]++; else discard and set err_overflow.
REQ-023 IDLE -> CAPTURE on the first posedge with any captured word (that word is stored).
REQ-024 CAPTURE -> WRITE the cycle after all row_cnt[c]==ROWS; row index r=0.
REQ-025 CAPTURE -> WRITE also when fsm_done=1 with any row_cnt[c]<ROWS; set err_short; unfilled entries write as 0.
REQ-026 WRITE (1 cycle): wr_mem_en=1, wr_mem_addr=OUT_BASE_ADDR+r*ADDR_INCR, wr_mem_data=buf row r, word c at [c*WORD_SIZE +: WORD_SIZE]; -> WAIT_MEM, load wait counter MEM_ACCESS_LATENCY-1.
REQ-027 WAIT_MEM: wr_mem_en=0; decrement counter; at counter==0 -> WRITE with r+1, or DONE if r==ROWS-1; row period = 1+MEM_ACCESS_LATENCY cycles.
REQ-028 wr_mem_addr/wr_mem_data hold last driven values outside WRITE; only wr_mem_en qualifies them.
REQ-029 DONE: wr_output_done=1 while fsm_done=1; when fsm_done=0 -> IDLE, wr_output_done=0, buffer and row_cnt cleared to 0, wr_output_rdy=1 next cycle.
REQ-030 In WRITE/WAIT_MEM/DONE, output_col_valid is ignored (set err_overflow if any bit high with stall=0).
REQ-031 fsm_done in IDLE with empty buffer: ignored; no writes, no done.
REQ-032 err_overflow/err_short clear only on rst.

Reset
REQ-033 On rst (any state, mid-write included): state=IDLE, wr_output_rdy=1, wr_output_done=0, wr_mem_en=0, wr_mem_addr=0, wr_mem_data=0, row_cnt=0, buffer=0, err_overflow=0, err_short=0.
REQ-034 A write in progress at rst is abandoned; no further wr_mem_en until a new capture completes.

Verification (ROWS=COLS=4, WORD_SIZE=16, MEM_ACCESS_LATENCY=2, defaults)
REQ-035 Skewed stream: col c valid cycles c..c+3, word = 16'h(r)(c)00 -> 4 writes, 3 cycles apart, addr 0x200/0x204/0x208/0x20C, row r data {16'h(r)300,16'h(r)200,16'h(r)100,16'h(r)000}; then fsm_done=1 -> wr_output_done=1; fsm_done=0 -> wr_output_rdy=1 next cycle.
REQ-036 stall=1 on cycle 2 of stream, valid held one extra cycle -> same 4 rows as REQ-035, no duplicate words, no error flags.
REQ-037 Col 0 valid 5 times -> 5th word discarded, err_overflow=1, row data unchanged.
REQ-038 Only 2 rows delivered then fsm_done=1 -> 4 writes, rows 2-3 all zero, err_short=1.
REQ-039 rst asserted during WAIT_MEM after row 1 -> next cycle wr_mem_en=0, wr_output_rdy=1, flags 0; fresh stream writes from 0x200.
REQ-040 fsm_done pulsed in IDLE with no valid data -> no wr_mem_en, wr_output_done stays 0.

Source files
------------

// File: rtl/systolic_output_writer.sv
// systolic_output_writer: gathers skewed systolic bottom_out words into a ROWS x COLS buffer, then writes it to RAM row by row.
// Latency: first RAM write 2 cycles after the last column fills; then one row every 1+MEM_ACCESS_LATENCY cycles.
// Backpressure: none toward the array; stall suppresses capture, words that cannot be stored are dropped and flagged.

module systolic_output_writer #(
    parameter int          ROWS               = 4,
    parameter int          COLS               = 4,
    parameter int          WORD_SIZE          = 16,
    parameter int          MEM_ACCESS_LATENCY = 2,
    parameter logic [31:0] OUT_BASE_ADDR      = 32'h0000_0200,
    parameter int          ADDR_INCR          = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [COLS*WORD_SIZE-1:0] matmul_output,
    input  logic [COLS-1:0]           output_col_valid,
    input  logic                      stall,
    input  logic                      fsm_done,
    output logic                      wr_output_rdy,
    output logic                      wr_output_done,
    output logic [31:0]               wr_mem_addr,
    output logic                      wr_mem_en,
    output logic [COLS*WORD_SIZE-1:0] wr_mem_data,
    output logic                      err_overflow,
    output logic                      err_short
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(ROWS + 1);
    localparam int WW = $clog2(MEM_ACCESS_LATENCY + 1);

    localparam logic [CW-1:0] FULL_CNT  = CW'(ROWS);
    localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(MEM_ACCESS_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        WRITE,
        WAIT_MEM,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Result buffer and per-column fill counters
    logic [WORD_SIZE-1:0] row_buf [ROWS][COLS];
    logic [CW-1:0]        row_cnt [COLS];

    // Write sequencing
    logic [RW-1:0]            row_idx;
    logic [WW-1:0]            wait_cnt;
    logic [31:0]              last_addr;
    logic [COLS*WORD_SIZE-1:0] last_data;
    logic [31:0]              cur_addr;
    logic [COLS*WORD_SIZE-1:0] cur_data;

    // Capture decode
    logic            accepting;
    logic [COLS-1:0] cap_en;
    logic            ovf_hit;
    logic            all_full;
    logic            clear_buf;

    assign accepting = (state == IDLE) || (state == CAPTURE);
    assign clear_buf = (state == DONE) && !fsm_done;

    // Decide per column whether this cycle's word is stored or dropped as overflow
    always_comb begin
        cap_en   = '0;
        ovf_hit  = 1'b0;
        all_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (row_cnt[c] != FULL_CNT) begin
                all_full = 1'b0;
            end
            if (output_col_valid[c] && !stall) begin
                if (accepting && (row_cnt[c] != FULL_CNT)) begin
                    cap_en[c] = 1'b1;
                end else begin
                    ovf_hit = 1'b1;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a short fill is forced into the write phase by fsm_done
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|cap_en) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (all_full || fsm_done) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = WAIT_MEM;
            end
            WAIT_MEM: begin
                if (wait_cnt == '0) begin
                    state_nxt = (row_idx == LAST_ROW) ? DONE : WRITE;
                end
            end
            DONE: begin
                if (!fsm_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Buffer fill, overflow flag, and buffer clear on leaving DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    row_buf[r][c] <= '0;
                end
            end
            for (int c = 0; c < COLS; c++) begin
                row_cnt[c] <= '0;
            end
            err_overflow <= 1'b0;
        end else begin
            if (clear_buf) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        row_buf[r][c] <= '0;
                    end
                end
                for (int c = 0; c < COLS; c++) begin
                    row_cnt[c] <= '0;
                end
            end else begin
                for (int c = 0; c < COLS; c++) begin
                    if (cap_en[c]) begin
                        row_buf[row_cnt[c][RW-1:0]][c] <= matmul_output[c*WORD_SIZE +: WORD_SIZE];
                        row_cnt[c]                      <= row_cnt[c] + 1'b1;
                    end
                end
            end
            if (ovf_hit) begin
                err_overflow <= 1'b1;
            end
        end
    end

    // Row index, RAM recovery counter, held write outputs, short-fill flag
    always_ff @(posedge clk) begin
        if (rst) begin
            row_idx   <= '0;
            wait_cnt  <= '0;
            last_addr <= '0;
            last_data <= '0;
            err_short <= 1'b0;
        end else begin
            case (state)
                CAPTURE: begin
                    if (all_full || fsm_done) begin
                        row_idx <= '0;
                        if (!all_full) begin
                            err_short <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    wait_cnt  <= WAIT_LOAD;
                    last_addr <= cur_addr;
                    last_data <= cur_data;
                end
                WAIT_MEM: begin
                    if (wait_cnt == '0) begin
                        if (row_idx != LAST_ROW) begin
                            row_idx <= row_idx + 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Current row address/data; outside WRITE the last driven values are held
    always_comb begin
        cur_addr = OUT_BASE_ADDR + (32'(row_idx) * 32'(ADDR_INCR));
        cur_data = '0;
        for (int c = 0; c < COLS; c++) begin
            cur_data[c*WORD_SIZE +: WORD_SIZE] = row_buf[row_idx][c];
        end
        wr_mem_en      = (state == WRITE);
        wr_mem_addr    = wr_mem_en ? cur_addr : last_addr;
        wr_mem_data    = wr_mem_en ? cur_data : last_data;
        wr_output_rdy  = (state == IDLE);
        wr_output_done = (state == DONE) && fsm_done;
    end

endmodule

// File: tb/tb_systolic_output_writer.sv
// Bench for systolic_output_writer: skewed streams in, RAM writes checked against a queue of expected rows.
// Expected rows come from a plain array model of the result matrix filled as words are presented.
// A negedge monitor pops the queue on every wr_mem_en and also checks row spacing.

module tb_systolic_output_writer;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int WS   = 16;
    localparam int MAL  = 2;
    localparam int DW   = COLS * WS;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] matmul_output;
    logic [COLS-1:0] output_col_valid;
    logic          stall;
    logic          fsm_done;
    logic          wr_output_rdy;
    logic          wr_output_done;
    logic [31:0]   wr_mem_addr;
    logic          wr_mem_en;
    logic [DW-1:0] wr_mem_data;
    logic          err_overflow;
    logic          err_short;

    systolic_output_writer #(
        .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WS), .MEM_ACCESS_LATENCY(MAL),
        .OUT_BASE_ADDR(32'h0000_0200), .ADDR_INCR(4)
    ) dut (
        .clk(clk), .rst(rst),
        .matmul_output(matmul_output), .output_col_valid(output_col_valid),
        .stall(stall), .fsm_done(fsm_done),
        .wr_output_rdy(wr_output_rdy), .wr_output_done(wr_output_done),
        .wr_mem_addr(wr_mem_addr), .wr_mem_en(wr_mem_en), .wr_mem_data(wr_mem_data),
        .err_overflow(err_overflow), .err_short(err_short)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   addr;
        logic [DW-1:0] data;
        int            row;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec  = 0;
    int  n_miss = 0;
    int  cyc    = 0;
    int  last_wr_cyc = 0;

    logic [WS-1:0] model_buf [ROWS][COLS];
    int            model_cnt [COLS];
    bit            model_ovf;
    bit            model_short;
    logic [WS-1:0] words [ROWS][COLS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every RAM write must match the next expected row
    always @(negedge clk) begin
        if (wr_mem_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_write: got addr %h data %h, no write expected", wr_mem_addr, wr_mem_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check($sformatf("wr_addr_row%0d", e.row), wr_mem_addr, e.addr);
                check($sformatf("wr_data_row%0d", e.row), wr_mem_data, e.data);
                if (e.row != 0) begin
                    check($sformatf("wr_spacing_row%0d", e.row), cyc - last_wr_cyc, 1 + MAL);
                end
                last_wr_cyc = cyc;
            end
        end
    end

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                model_buf[r][c] = '0;
        for (int c = 0; c < COLS; c++) model_cnt[c] = 0;
        model_ovf   = 1'b0;
        model_short = 1'b0;
    endtask

    task automatic apply_reset();
        rst              = 1'b1;
        output_col_valid = '0;
        matmul_output    = '0;
        stall            = 1'b0;
        fsm_done         = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        exp_q.delete();
        check("rst_rdy", wr_output_rdy, 1);
        check("rst_done", wr_output_done, 0);
        check("rst_en", wr_mem_en, 0);
        check("rst_addr", wr_mem_addr, 0);
        check("rst_data", wr_mem_data, 0);
        check("rst_ovf", err_overflow, 0);
        check("rst_short", err_short, 0);
    endtask

    task automatic make_words(input bit rnd);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                words[r][c] = rnd ? WS'($urandom) : {4'(r), 4'(c), 8'h00};
    endtask

    // Skewed stream: column c presents row r on effective cycle c+r.
    // stall_mode 0 none, 1 one stall on effective cycle 2, 2 random stalls.
    task automatic run_stream(input int nrows, input int stall_mode, input bit extra);
        int keff = 0;
        bit st;
        bit stalled_once = 1'b0;
        int r;
        logic [WS-1:0] w;
        while (keff < COLS - 1 + nrows) begin
            @(posedge clk);
            #1;
            case (stall_mode)
                1:       st = (keff == 2) && !stalled_once;
                2:       st = ($urandom_range(0, 3) == 0);
                default: st = 1'b0;
            endcase
            for (int c = 0; c < COLS; c++) begin
                r = keff - c;
                if (r >= 0 && r < nrows) begin
                    output_col_valid[c] = 1'b1;
                    matmul_output[c*WS +: WS] = words[r][c];
                end else if (extra && c == 0 && r == nrows) begin
                    output_col_valid[c] = 1'b1;
                    matmul_output[c*WS +: WS] = 16'hDEAD;
                end else begin
                    output_col_valid[c] = 1'b0;
                    matmul_output[c*WS +: WS] = WS'($urandom);
                end
            end
            stall = st;
            if (!st) begin
                for (int c = 0; c < COLS; c++) begin
                    if (output_col_valid[c]) begin
                        w = matmul_output[c*WS +: WS];
                        if (model_cnt[c] < ROWS) begin
                            model_buf[model_cnt[c]][c] = w;
                            model_cnt[c]++;
                        end else begin
                            model_ovf = 1'b1;
                        end
                    end
                end
                keff++;
            end else begin
                stalled_once = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        output_col_valid = '0;
        stall            = 1'b0;
    endtask

    task automatic push_expected(input int nwrites);
        wr_t e;
        for (int r = 0; r < nwrites; r++) begin
            e.addr = 32'h0000_0200 + 32'(4 * r);
            e.data = '0;
            for (int c = 0; c < COLS; c++) e.data[c*WS +: WS] = model_buf[r][c];
            e.row = r;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_writes();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("writes_drained", exp_q.size(), 0);
    endtask

    task automatic complete_handshake();
        int t = 0;
        @(posedge clk);
        #1 fsm_done = 1'b1;
        while (wr_output_done !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("done_high", wr_output_done, 1);
        check("rdy_low_in_done", wr_output_rdy, 0);
        check("err_overflow", err_overflow, model_ovf);
        check("err_short", err_short, model_short);
        @(posedge clk);
        #1 fsm_done = 1'b0;
        @(posedge clk);
        #1;
        check("rdy_after_done", wr_output_rdy, 1);
        check("done_low_after", wr_output_done, 0);
    endtask

    task automatic run_test(input int nrows, input int stall_mode, input bit extra, input bit rnd);
        apply_reset();
        make_words(rnd);
        run_stream(nrows, stall_mode, extra);
        if (nrows < ROWS) begin
            fsm_done    = 1'b1;
            model_short = 1'b1;
        end
        push_expected(ROWS);
        wait_writes();
        complete_handshake();
    endtask

    initial begin
        // plain skewed stream
        run_test(ROWS, 0, 1'b0, 1'b0);
        // one stall cycle mid-stream
        run_test(ROWS, 1, 1'b0, 1'b0);
        // fifth word on column 0
        run_test(ROWS, 0, 1'b1, 1'b0);
        // short delivery
        run_test(2, 0, 1'b0, 1'b0);

        // reset while waiting on RAM after row 1
        apply_reset();
        make_words(1'b1);
        run_stream(ROWS, 0, 1'b0);
        push_expected(2);
        wait_writes();
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_en", wr_mem_en, 0);
        check("midrst_rdy", wr_output_rdy, 1);
        check("midrst_ovf", err_overflow, 0);
        check("midrst_short", err_short, 0);
        check("midrst_addr", wr_mem_addr, 0);
        repeat (10) @(posedge clk);
        model_clear();
        make_words(1'b1);
        run_stream(ROWS, 0, 1'b0);
        push_expected(ROWS);
        wait_writes();
        complete_handshake();

        // fsm_done in IDLE with nothing captured
        apply_reset();
        @(posedge clk);
        #1 fsm_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_done_low", wr_output_done, 0);
            check("idle_rdy", wr_output_rdy, 1);
        end
        @(posedge clk);
        #1 fsm_done = 1'b0;
        repeat (8) @(posedge clk);
        check("idle_no_writes", exp_q.size(), 0);

        // randomized streams
        for (int i = 0; i < 8; i++) begin
            int nr;
            nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, ROWS - 1)) : ROWS;
            run_test(nr, 2, 1'($urandom_range(0, 1)), 1'b1);
        end

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_miss);
        $fatal(1, "watchdog");
    end

endmodule
